// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: registers one core request, drives DMEM through a
// request/ack handshake, then returns one extended/flagged response pulse.
module lsu_mc #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15,
    localparam int NL      = XLEN / 8,
    localparam int LB      = $clog2(NL)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   rdata,
    output logic              misaligned,
    output logic              timeout,
    output logic [ADDR_W-1:0] daddr,
    output logic [XLEN-1:0]   dwdata,
    output logic [NL-1:0]     dwe,
    output logic              dre,
    input  logic              dack,
    input  logic [XLEN-1:0]   drdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_wait;
    logic            r_is_store;
    logic [2:0]      r_f3;
    logic [LB-1:0]   r_lane;
    logic [LB-1:0]   w_lane;
    logic            w_accept;
    logic            w_req_ok;
    logic            w_wait_done;

    function automatic logic f_legal(input logic st, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b011:                 ok = (XLEN == 64);
            3'b100, 3'b101:         ok = !st;
            3'b110:                 ok = !st && (XLEN == 64);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f_aligned(input logic [2:0] f3, input logic [LB-1:0] lane);
        logic ok;
        case (f3[1:0])
            2'd0:    ok = 1'b1;
            2'd1:    ok = !lane[0];
            2'd2:    ok = (lane[1:0] == 2'b00);
            default: ok = (lane == '0);
        endcase
        return ok;
    endfunction

    function automatic logic [NL-1:0] f_mask(input logic [2:0] f3);
        logic [NL-1:0] m;
        case (f3[1:0])
            2'd0:    m = NL'(1);
            2'd1:    m = NL'(3);
            2'd2:    m = NL'(15);
            default: m = '1;
        endcase
        return m;
    endfunction

    // Pull the addressed bytes down to bit 0, then sign- or zero-extend by width code.
    function automatic logic [XLEN-1:0] f_ext(input logic [2:0] f3, input logic [LB-1:0] lane,
                                              input logic [XLEN-1:0] d);
        logic [XLEN-1:0]        s;
        logic signed [7:0]      b;
        logic signed [15:0]     h;
        logic signed [31:0]     w;
        logic signed [XLEN-1:0] e;
        s = d >> {lane, 3'b000};
        b = s[7:0];
        h = s[15:0];
        w = s[31:0];
        case (f3)
            3'b000:  e = XLEN'(b);
            3'b001:  e = XLEN'(h);
            3'b010:  e = XLEN'(w);
            3'b100:  e = s & XLEN'(32'h0000_00FF);
            3'b101:  e = s & XLEN'(32'h0000_FFFF);
            3'b110:  e = s & XLEN'(32'hFFFF_FFFF);
            default: e = s;
        endcase
        return e;
    endfunction

    assign req_ready   = (r_state == S_IDLE);
    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_lane      = addr[LB-1:0];
    assign w_req_ok    = f_legal(is_store, funct3) && f_aligned(funct3, w_lane);
    assign w_wait_done = (r_wait == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = w_req_ok ? S_ACCESS : S_RESP;
            S_ACCESS: if (dack || w_wait_done) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_store <= is_store;
            r_f3       <= funct3;
            r_lane     <= w_lane;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait     <= '0;
            dre        <= 1'b0;
            dwe        <= '0;
            daddr      <= '0;
            dwdata     <= '0;
            rdata      <= '0;
            misaligned <= 1'b0;
            timeout    <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    if (w_accept) begin
                        if (w_req_ok) begin
                            daddr <= {addr[ADDR_W-1:LB], {LB{1'b0}}};
                            if (is_store) begin
                                dwe    <= f_mask(funct3) << w_lane;
                                dwdata <= wdata << {w_lane, 3'b000};
                            end else begin
                                dre <= 1'b1;
                            end
                        end else begin
                            misaligned <= 1'b1;
                            rdata      <= '0;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack arriving on the final allowed cycle still completes normally.
                    if (dack) begin
                        dre        <= 1'b0;
                        dwe        <= '0;
                        rdata      <= r_is_store ? '0 : f_ext(r_f3, r_lane, drdata);
                        resp_valid <= 1'b1;
                    end else if (w_wait_done) begin
                        dre        <= 1'b0;
                        dwe        <= '0;
                        rdata      <= '0;
                        timeout    <= 1'b1;
                        resp_valid <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    misaligned <= 1'b0;
                    timeout    <= 1'b0;
                    rdata      <= '0;
                end
            endcase
        end
    end

endmodule
